data_bus_rr_arbiter: RTL and testbench
======================================

Name: data_bus_rr_arbiter

Overview:
- Shares the producer side of interface I (modport P1, field `data` of type data_t) between N_REQ requesters.
- Grants the bus round-robin, in bursts of up to MAX_BURST beats, with a req/ack handshake per beat.
- Registers the granted requester's data_t onto p1.data and pulses o_valid for the consumer on the P2 side.
- Sits between multiple M1-style producers and the shared I instance in top.

Parameters:
N_REQ, 4, number of requesters; must be >= 1.
MAX_BURST, 4, maximum beats per grant before forced rotation; must be >= 1.
IDLE_VALUE, 8'h00, value driven on p1.data out of reset.

Ports:
i_clk  input  1  clock; all state on rising edge.
i_rst_n  input  1  asynchronous, active-low reset.
i_req  input  N_REQ  per-requester request; held high while the requester has data.
i_data  input  data_t [N_REQ] (unpacked)  per-requester payload.
o_ack  output  N_REQ  one-hot/zero; beat accepted at this edge, requester advances its data.
p1  modport I.P1  data_t  shared bus; p1.data driven by this block only.
o_valid  output  1  one-cycle pulse: p1.data holds a newly transferred beat.
o_grant  output  $clog2(N_REQ) (min 1)  index of the current/last granted requester.
o_busy  output  1  high while in GRANT.

Behaviour:
- Reset values (async, take effect immediately on i_rst_n low):
  - state=IDLE, ptr=0, burst count=0.
  - p1.data=IDLE_VALUE, o_valid=0, o_ack=0, o_grant=0, o_busy=0.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If any i_req is high, pick the first requester at or after ptr, wrapping modulo N_REQ.
  - Register o_grant=g, count=0, go to GRANT. No transfer in IDLE.
  - If no request, stay in IDLE.
- GRANT, o_ack (combinational):
  - o_ack[g] = i_req[g]; all other bits are 0.
  - A transfer occurs at the edge where o_ack[g]=1.
- GRANT, on transfer:
  - Next cycle: p1.data=i_data[g] sampled at that edge, o_valid=1; count increments.
  - If count reaches MAX_BURST: go to IDLE, ptr=(g+1) mod N_REQ.
- GRANT, i_req[g]=0: no transfer, go to IDLE, ptr=(g+1) mod N_REQ.
- Latency:
  - Request seen in IDLE to first o_ack: 1 cycle.
  - o_ack to p1.data/o_valid: 1 cycle.
  - One IDLE bubble between bursts, so peak throughput is MAX_BURST/(MAX_BURST+1).
- p1.data holds the last transferred value whenever o_valid=0.
- Other requests arriving mid-burst are ignored until the burst ends; a request is never dropped, only delayed.
- Simultaneous edge where the burst hits its limit and i_req[g] is still high: burst still ends, ptr advances past g.
- N_REQ=1: grant is always 0; the bubble still applies.
- MAX_BURST=1: strict per-beat rotation.
- ptr wrap: the increment from N_REQ-1 goes to 0.
- The count width must hold MAX_BURST: $clog2(MAX_BURST+1).

Decomposition:
- Package data_bus_pkg:
  - data_t typedef, moved out of global scope.
  - State enum {IDLE, GRANT}.
  - Helper localparam for the index width.
- Interface I imports data_t from the package.
- One combinational sub-module, rr_pick: inputs req vector and ptr; outputs found flag and granted index.
  - Separately unit-testable.
  - The FSM, counter and output registers stay in data_bus_rr_arbiter.

Test Plan:
- Reset: hold i_rst_n=0 with requests active -> p1.data=8'h00, o_valid=0, o_ack=0, o_busy=0, o_grant=0. Assert reset between edges -> outputs clear without waiting for a clock.
- Single requester, MAX_BURST=4: req[2] held, data A0,A1,... advancing on ack.
  - Acks in cycles 1-4; p1.data A0-A3 with o_valid in cycles 2-5.
  - IDLE in cycle 5; next ack in cycle 6; A4 appears in cycle 7.
- All four requesting continuously -> grant order 0,1,2,3,0; each burst is 4 o_valid pulses followed by 1 idle cycle.
- Mid-burst drop: req[1] deasserts after 2 acks while req[3] is high -> o_busy falls next edge, ptr=2, requester 3 granted in the following cycle.
- Rotation: ptr=2 with req[1] and req[3] high -> 3 granted first, then 1 (wrap past 0).
- Reset mid-burst: assert i_rst_n=0 after 2 beats of requester 2, then release -> next grant is chosen from ptr=0 (requester 0 if requesting); no stale o_valid.

Source files
------------

// File: rtl/data_bus_pkg.sv
// rtl/data_bus_pkg.sv - shared types, FSM states and index-width helper for the data bus arbiter
package data_bus_pkg;

    typedef logic [7:0] data_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // A single requester still needs a one-bit index port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_N_REQ = 4;
    localparam int DEF_IDX_W = idx_width(DEF_N_REQ);

endpackage

// File: rtl/I.sv
// rtl/I.sv - shared data bus: P1 drives the data word, P2 consumes it
interface I;
    import data_bus_pkg::*;

    data_t data;

    modport P1 (output data);
    modport P2 (input  data);

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first requester at or after ptr, wrapping
module rr_pick
    import data_bus_pkg::*;
#(
    parameter int N = 4,
    parameter int W = idx_width(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic         o_found,
    output logic [W-1:0] o_idx
);

    logic [W-1:0] cand;

    // Scan from the farthest offset down so the nearest candidate wins last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        cand    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = W'((int'(i_ptr) + k) % N);
            if (i_req[cand]) begin
                o_found = 1'b1;
                o_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/data_bus_rr_arbiter.sv
// rtl/data_bus_rr_arbiter.sv - round-robin burst arbiter sharing the P1 side of the data bus
module data_bus_rr_arbiter
    import data_bus_pkg::*;
#(
    parameter int    N_REQ      = 4,
    parameter int    MAX_BURST  = 4,
    parameter data_t IDLE_VALUE = 8'h00
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [N_REQ-1:0]            i_req,
    input  data_t                       i_data [N_REQ],
    output logic [N_REQ-1:0]            o_ack,
    I.P1                                p1,
    output logic                        o_valid,
    output logic [idx_width(N_REQ)-1:0] o_grant,
    output logic                        o_busy
);

    localparam int GW = idx_width(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t    state_q, state_d;
    logic [GW-1:0] ptr_q, ptr_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [CW-1:0] cnt_q, cnt_d;
    data_t         data_q, data_d;
    logic          valid_q, valid_d;

    logic          pick_found;
    logic [GW-1:0] pick_idx;
    logic [GW-1:0] ptr_after_grant;
    logic [CW-1:0] cnt_inc;
    logic          xfer;

    rr_pick #(
        .N (N_REQ),
        .W (GW)
    ) u_pick (
        .i_req   (i_req),
        .i_ptr   (ptr_q),
        .o_found (pick_found),
        .o_idx   (pick_idx)
    );

    assign xfer            = (state_q == GRANT) && i_req[grant_q];
    assign cnt_inc         = cnt_q + 1'b1;
    assign ptr_after_grant = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        o_ack = '0;
        if (xfer) begin
            o_ack[grant_q] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (xfer) begin
                    data_d  = i_data[grant_q];
                    valid_d = 1'b1;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == CW'(MAX_BURST)) begin
                        state_d = IDLE;
                        ptr_d   = ptr_after_grant;
                    end
                end else begin
                    // Requester went quiet mid-burst: give up the bus early.
                    state_d = IDLE;
                    ptr_d   = ptr_after_grant;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            data_q  <= IDLE_VALUE;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign p1.data = data_q;
    assign o_valid = valid_q;
    assign o_grant = grant_q;
    assign o_busy  = (state_q == GRANT);

endmodule

// File: tb/tb_data_bus_rr_arbiter.sv
// tb/tb_data_bus_rr_arbiter.sv - randomized self-checking bench for data_bus_rr_arbiter
module tb_data_bus_rr_arbiter;
    import data_bus_pkg::*;

    localparam int N_REQ     = 4;
    localparam int MAX_BURST = 4;
    localparam int GW        = 2;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_REQ-1:0] req   = '0;
    logic [N_REQ-1:0] ack;
    data_t            din [N_REQ];
    logic             valid;
    logic             busy;
    logic [GW-1:0]    grant;

    I bus ();

    data_bus_rr_arbiter #(
        .N_REQ      (N_REQ),
        .MAX_BURST  (MAX_BURST),
        .IDLE_VALUE (8'h00)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_req   (req),
        .i_data  (din),
        .o_ack   (ack),
        .p1      (bus.P1),
        .o_valid (valid),
        .o_grant (grant),
        .o_busy  (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int    seq [N_REQ];
    logic  en  [N_REQ];
    int    m_owner, m_beats, m_ptr, m_grant, m_valid;
    data_t m_data;
    int    nvalid;
    logic  busy_prev;
    int    grant_log [$];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic refresh_din();
        for (int i = 0; i < N_REQ; i++) din[i] = data_t'(i * 64 + seq[i] % 64);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_beats = 0;
        m_ptr   = 0;
        m_grant = 0;
        m_valid = 0;
        m_data  = 8'h00;
    endtask

    // One clock: check at negedge against the model, advance the model for the
    // coming edge, then let acked requesters move to their next word.
    task automatic step();
        int exp_ack;
        int cand;
        bit hit;
        @(negedge clk);
        if (!rst_n) model_reset();
        exp_ack = (m_owner >= 0 && req[m_owner]) ? (1 << m_owner) : 0;
        check("ack",   int'(ack),      exp_ack);
        check("busy",  int'(busy),     int'(m_owner >= 0));
        check("grant", int'(grant),    m_grant);
        check("valid", int'(valid),    m_valid);
        check("data",  int'(bus.data), int'(m_data));
        if (valid) nvalid++;
        if (busy && !busy_prev) grant_log.push_back(int'(grant));
        busy_prev = busy;
        if (rst_n) begin
            if (m_owner < 0) begin
                m_valid = 0;
                hit     = 0;
                for (int k = 0; k < N_REQ; k++) begin
                    cand = (m_ptr + k) % N_REQ;
                    if (req[cand] && !hit) begin
                        hit     = 1;
                        m_owner = cand;
                        m_grant = cand;
                        m_beats = 0;
                    end
                end
            end else if (req[m_owner]) begin
                m_data  = din[m_owner];
                m_valid = 1;
                m_beats++;
                if (m_beats == MAX_BURST) begin
                    m_ptr   = (m_owner + 1) % N_REQ;
                    m_owner = -1;
                end
            end else begin
                m_valid = 0;
                m_ptr   = (m_owner + 1) % N_REQ;
                m_owner = -1;
            end
        end
        @(posedge clk);
        #1;
        if (rst_n) begin
            for (int i = 0; i < N_REQ; i++) if (exp_ack[i]) seq[i]++;
        end
        refresh_din();
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        for (int c = 0; c < cycles; c++) step();
        rst_n = 1'b1;
        busy_prev = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N_REQ; i++) begin
            seq[i] = 0;
            en[i]  = 1'b0;
        end
        refresh_din();
        model_reset();
        busy_prev = 1'b0;

        // Reset held with every requester active.
        req = 4'hF;
        #2;
        do_reset(2);

        // All four requesting continuously.
        nvalid = 0;
        grant_log.delete();
        for (int c = 0; c < 26; c++) step();
        check("all_valid_count", nvalid, 20);
        check("all_grant_n", grant_log.size(), 5);
        if (grant_log.size() == 5) begin
            for (int j = 0; j < 5; j++) check("all_grant_order", grant_log[j], j % 4);
        end

        // Mid-burst drop by requester 1 while 3 waits.
        req = 4'h0;
        do_reset(1);
        req = 4'b1010;
        for (int c = 0; c < 3; c++) step();
        req = 4'b1000;
        for (int c = 0; c < 3; c++) step();
        check("drop_grant", int'(grant), 3);
        check("drop_busy", int'(busy), 1);

        // Reset mid-burst of requester 2, asserted between clock edges.
        req = 4'h0;
        do_reset(1);
        req = 4'b0100;
        for (int c = 0; c < 3; c++) step();
        rst_n = 1'b0;
        #1;
        check("async_valid", int'(valid), 0);
        check("async_busy", int'(busy), 0);
        check("async_ack", int'(ack), 0);
        check("async_grant", int'(grant), 0);
        check("async_data", int'(bus.data), 0);
        step();
        rst_n = 1'b1;
        busy_prev = 1'b0;
        req = 4'b0101;
        for (int c = 0; c < 2; c++) step();
        check("rst_ptr_grant", int'(grant), 0);

        // Randomized traffic with requests coming and going.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if ($urandom_range(3) == 0) en[i] = ~en[i];
                req[i] = en[i];
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
